music_player_ctrl: RTL
======================

// Module: music_player_ctrl
// PURPOSE
// - Sequencer and tone generator placed before and after the music score ROM. Drives the ROM address one beat at a time.
// - Latches the 12-bit {high,med,low} note code from the ROM, decodes it into a tone period and drives a square wave to the buzzer pin.
// - Provides start, pause, playing and done control for the top-level UI.
// PARAMETERS
// - CLK_FREQ     100_000_000  system clock frequency in Hz
// - BEAT_CYCLES  12_500_000   clock cycles per ROM entry (one beat)
// - SCORE_LEN    135          number of valid ROM entries
// - ADDR_WIDTH   8            ROM address width
// - ROM_WIDTH    12           ROM data width, {high[3:0],med[3:0],low[3:0]}
// PORTS
// - clk       in   1           system clock, single clock domain
// - rst       in   1           synchronous, active-high reset
// - start     in   1           1-cycle pulse: (re)start playback from address 0
// - pause     in   1           level: hold playback while high
// - rom_addr  out  ADDR_WIDTH  address to the score ROM (registered)
// - rom_data  in   ROM_WIDTH   combinational ROM data for rom_addr
// - buzzer    out  1           square-wave tone output (registered)
// - playing   out  1           high in PLAY and PAUSE
// - done      out  1           high in DONE until the next start or rst
// BEHAVIOUR
// - Reset: state=IDLE, rom_addr=0, beat_cnt=0, tone_cnt=0, note=0, buzzer=0, playing=0, done=0.
// - States: IDLE, PLAY, PAUSE, DONE. start from any state -> PLAY, with rom_addr=0, beat_cnt=0, tone_cnt=0, buzzer=0, done=0.
// - Same-cycle start and pause: start wins. If pause is still high on the next cycle, the state goes to PAUSE.
// - PLAY with pause=1 -> PAUSE. PAUSE with pause=0 -> PLAY, resuming mid-beat. In PAUSE, beat_cnt, tone_cnt and rom_addr hold and buzzer=0.
// - Note latch: in PLAY, when beat_cnt==0, note<=rom_data and tone_cnt<=0. Buzzer is 0 on the cycle the note is latched.
// - Beat end: in PLAY, when beat_cnt==BEAT_CYCLES-1, beat_cnt<=0.
//   - If rom_addr==SCORE_LEN-1: go to DONE (see CONFIGURATION).
//   - Otherwise rom_addr<=rom_addr+1.
// - Beat timing: beat k starts exactly k*BEAT_CYCLES cycles after the first PLAY cycle, not counting PAUSE cycles.
// - Decode priority: high nibble, then med, then low. The first nonzero field selects degree d and octave o (high=2, med=1, low=0).
//   - All fields zero, or the selected digit is 8..F: rest, buzzer held 0.
// - Base frequencies f[1..7] = 262,294,330,349,392,440,494 Hz.
//   - Half period HP = CLK_FREQ / (2*f[d]*2^o), truncating integer division, computed at elaboration.
//   - Constants are 32 bits. HP==0 is treated as rest.
// - Tone: tone_cnt counts 0..HP-1. At HP-1, buzzer toggles and tone_cnt<=0. Period is 2*HP cycles.
// - DONE: buzzer=0, done=1, rom_addr holds SCORE_LEN-1, pause is ignored.
// CONFIGURATION
// - MUSIC_LOOP_EN defined: at the beat end of address SCORE_LEN-1, rom_addr<=0 and the state stays PLAY. DONE is never entered and done stays 0.
// - MUSIC_LOOP_EN undefined: at that beat end, the state goes to DONE as above.
// TESTING
// - Test parameters: CLK_FREQ=52_400, BEAT_CYCLES=256, SCORE_LEN=4. ROM model holds {0,0,1},{0,1,0},{1,0,0},{0,0,0}.
// - rst high 2 cycles, then start pulse:
//   - all outputs 0 during reset
//   - playing=1 the cycle after start, rom_addr steps 0->1->2->3 every 256 cycles
// - Beat 0 (low 1, HP=100): buzzer toggles every 100 cycles. Beat 1 (med 1): HP=50. Beat 2 (high 1): HP=25. Beat 3 (rest): buzzer stays 0.
// - Without MUSIC_LOOP_EN: 1024 cycles after start, done=1, playing=0, buzzer=0, rom_addr=3. A further start restarts at rom_addr=0.
// - pause high for 300 cycles at cycle 100 of beat 1:
//   - buzzer=0 and rom_addr=1 while paused
//   - after release, beat 1 ends 156 cycles later
// - ROM word 12'hF95 (invalid high digit) -> rest. Start pulse mid-beat 2 -> rom_addr=0 next cycle, note relatched.
// - With MUSIC_LOOP_EN: rom_addr wraps 3->0 and done stays 0 across 3 full passes.

Source files
------------

// File: rtl/music_player_ctrl.sv
// music_player_ctrl: score ROM sequencer and square-wave tone generator; optional MUSIC_LOOP_EN replays the score forever
module music_player_ctrl #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int SCORE_LEN   = 135,
   parameter int ADDR_WIDTH  = 8,
   parameter int ROM_WIDTH   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_pause,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [ROM_WIDTH-1:0]  i_rom_data,
   output logic                  o_buzzer,
   output logic                  o_playing,
   output logic                  o_done
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic int base_freq(input int d);
      return d == 0 ? 262 : d == 1 ? 294 : d == 2 ? 330 : d == 3 ? 349 :
             d == 4 ? 392 : d == 5 ? 440 : 494;
   endfunction

   // half periods for 7 degrees x 3 octaves, entry index = octave*7 + degree-1
   function automatic logic [21*32-1:0] build_hp();
      logic [21*32-1:0] t;
      t = '0;
      for (int i = 0; i < 21; i++)
         t[i*32 +: 32] = 32'(CLK_FREQ / (2 * base_freq(i % 7) * (1 << (i / 7))));
      return t;
   endfunction

   localparam logic [21*32-1:0] HP_TAB = build_hp();

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_beat_cnt;
   logic [31:0]           r_tone_cnt;
   logic [ROM_WIDTH-1:0]  r_note;
   logic                  r_buzzer;

   logic [3:0]  w_hi, w_md, w_lo, w_sel;
   logic [1:0]  w_oct;
   logic [4:0]  w_idx;
   logic [31:0] w_hp;
   logic        w_rest, w_silent, w_active, w_last_beat, w_last_addr;

   assign w_hi        = r_note[11:8];
   assign w_md        = r_note[7:4];
   assign w_lo        = r_note[3:0];
   assign w_sel       = |w_hi ? w_hi : |w_md ? w_md : w_lo;
   assign w_oct       = |w_hi ? 2'd2 : |w_md ? 2'd1 : 2'd0;
   assign w_rest      = w_sel == 4'd0 || w_sel[3];
   assign w_idx       = w_rest ? 5'd0 : 5'(w_oct) * 5'd7 + {2'b00, w_sel[2:0]} - 5'd1;
   assign w_hp        = HP_TAB[32*w_idx +: 32];
   assign w_silent    = w_rest || w_hp == 32'd0;
   assign w_active    = r_state == S_PLAY || r_state == S_PAUSE;
   assign w_last_beat = r_beat_cnt == 32'(BEAT_CYCLES - 1);
   assign w_last_addr = r_addr == ADDR_WIDTH'(SCORE_LEN - 1);

   // playback FSM: beat counting, note latch, tone toggling; beat-end logic last so DONE silences the buzzer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_beat_cnt <= '0;
         r_tone_cnt <= '0;
         r_note     <= '0;
         r_buzzer   <= 1'b0;
      end else if (i_start) begin
         r_state    <= S_PLAY;
         r_addr     <= '0;
         r_beat_cnt <= '0;
         r_tone_cnt <= '0;
         r_buzzer   <= 1'b0;
      end else if (w_active) begin
         r_state <= i_pause ? S_PAUSE : S_PLAY;
         if (i_pause) begin
            r_buzzer <= 1'b0;
         end else begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 32'd1;
            if (r_beat_cnt == 32'd0) begin
               r_note     <= i_rom_data;
               r_tone_cnt <= '0;
               r_buzzer   <= 1'b0;
            end else if (w_silent) begin
               r_tone_cnt <= '0;
               r_buzzer   <= 1'b0;
            end else if (r_tone_cnt == w_hp - 32'd1) begin
               r_tone_cnt <= '0;
               r_buzzer   <= ~r_buzzer;
            end else begin
               r_tone_cnt <= r_tone_cnt + 32'd1;
            end
            if (w_last_beat) begin
`ifdef MUSIC_LOOP_EN
               r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
`else
               if (w_last_addr) begin
                  r_state  <= S_DONE;
                  r_buzzer <= 1'b0;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
`endif
            end
         end
      end
   end

   assign o_rom_addr = r_addr;
   assign o_buzzer   = r_buzzer;
   assign o_playing  = w_active;
   assign o_done     = r_state == S_DONE;
endmodule
